// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 Wishbone sequencer: register map, bit fields,
// sequencer state encoding and datapath widths.
package sha1_pkg;

  localparam int DIGEST_W  = 160;
  localparam int BLOCK_W   = 512;
  localparam int MSG_WORDS = 16;
  localparam int DIG_WORDS = 5;

  // Register offsets within the 256-byte window
  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_STAT = 8'h04;
  localparam logic [7:0] OFF_MSG  = 8'h40;
  localparam logic [7:0] OFF_DIG  = 8'h80;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_INIT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STAT bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_e;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sha1_wb_sequencer_if.sv
// Wishbone slave bus bundle between the user_project_wrapper and the sequencer.
interface sha1_wb_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/sha1_wb_regif.sv
// Register interface: address decode, registered single-cycle ack, read mux and
// the 16-word message store that feeds the SHA-1 core.
module sha1_wb_regif
  import sha1_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                clk,
  input  logic                rst,
  sha1_wb_sequencer_if.slave  wbs,
  input  logic                busy,
  input  logic                done,
  input  logic                err,
  input  logic                init,
  input  logic                irq_en,
  input  logic [DIGEST_W-1:0] dig,
  output logic                ctrl_wr,
  output logic                stat_wr,
  output logic [2:0]          wr_bits,
  output logic [BLOCK_W-1:0]  block
);

  logic [31:0] msg [MSG_WORDS];
  logic [7:0]  off;
  logic        hit, req, wr_req;
  logic        is_msg, is_dig;
  logic [31:0] rdata;

  assign off    = wbs.wbs_adr_i[7:0];
  assign hit    = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  // The !ack term spaces back-to-back strobes onto alternate cycles
  assign req    = wbs.wbs_stb_i && wbs.wbs_cyc_i && hit && !wbs.wbs_ack_o;
  assign wr_req = req && wbs.wbs_we_i;

  assign is_msg = (off[7:6] == 2'b01) && (off[1:0] == 2'b00);
  assign is_dig = (off[7:5] == 3'b100) && (off[4:2] <= 3'd4) && (off[1:0] == 2'b00);

  assign ctrl_wr = wr_req && (off == OFF_CTRL);
  assign stat_wr = wr_req && (off == OFF_STAT);
  assign wr_bits = wbs.wbs_dat_i[2:0];

  // Message store: byte-lane writes, frozen while the core is busy
  // NOTE: the message words are reset because core_block must read 0 after reset;
  // a plain RAM without reset would leave X on the core input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_WORDS; i++) msg[i] <= '0;
    end else if (wr_req && is_msg && !busy) begin
      for (int b = 0; b < 4; b++) begin
        // NOTE: sequential state always uses <= so every flop samples pre-edge values.
        if (wbs.wbs_sel_i[b]) msg[off[5:2]][8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
      end
    end
  end

  // Pack the message words, word0 in the top bits
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    block = '0;
    for (int i = 0; i < MSG_WORDS; i++) block[BLOCK_W-1-32*i -: 32] = msg[i];
  end

  // Read mux; unmapped offsets return 0
  always_comb begin
    rdata = '0;
    if (off == OFF_CTRL) begin
      rdata[CTRL_INIT]   = init;
      rdata[CTRL_IRQ_EN] = irq_en;
    end else if (off == OFF_STAT) begin
      rdata[STAT_BUSY] = busy;
      rdata[STAT_DONE] = done;
      rdata[STAT_ERR]  = err;
    end else if (is_msg) begin
      rdata = msg[off[5:2]];
    end else if (is_dig) begin
      for (int i = 0; i < DIG_WORDS; i++) begin
        if (off[4:2] == 3'(i)) rdata = dig[DIGEST_W-1-32*i -: 32];
      end
    end
  end

  // Registered ack and read data, data is zero outside a read ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
    end else begin
      wbs.wbs_ack_o <= req;
      wbs.wbs_dat_o <= (req && !wbs.wbs_we_i) ? rdata : '0;
    end
  end

endmodule

// File: rtl/sha1_wb_sequencer.sv
// SHA-1 job sequencer: firmware loads a block and writes START; this block pulses
// the core, waits for done (with timeout), captures the digest and raises irq.
module sha1_wb_sequencer
  import sha1_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd1023
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  sha1_wb_sequencer_if.slave  wbs,
  output logic                core_start,
  output logic                core_init,
  output logic [BLOCK_W-1:0]  core_block,
  input  logic                core_done,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic                irq
);

  seq_state_e          state_q, state_d;
  logic [15:0]         cnt_q, cnt_inc;
  logic                busy, done_q, err_q, init_q, irq_en_q;
  logic [DIGEST_W-1:0] dig_q;
  logic                ctrl_wr, stat_wr;
  logic [2:0]          wr_bits;
  logic                start_req, timeout_hit, run_done, run_timeout;

  assign busy        = (state_q != ST_IDLE);
  assign start_req   = ctrl_wr && wr_bits[CTRL_START] && !busy;
  assign cnt_inc     = sat_inc(cnt_q);
  assign timeout_hit = (cnt_inc >= TIMEOUT);
  assign run_done    = (state_q == ST_RUN) && core_done;
  assign run_timeout = (state_q == ST_RUN) && !core_done && timeout_hit;

  sha1_wb_regif #(.BASE_ADR(BASE_ADR)) u_regif (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .wbs     (wbs),
    .busy    (busy),
    .done    (done_q),
    .err     (err_q),
    .init    (init_q),
    .irq_en  (irq_en_q),
    .dig     (dig_q),
    .ctrl_wr (ctrl_wr),
    .stat_wr (stat_wr),
    .wr_bits (wr_bits),
    .block   (core_block)
  );

  // Sequencer state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and the one-cycle core start pulse
  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_req) state_d = ST_START;
      ST_START: begin
        core_start = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN:   if (run_done || run_timeout) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Timeout counter: cleared on START, counts every RUN cycle, saturates
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)               cnt_q <= '0;
    else if (start_req)         cnt_q <= '0;
    else if (state_q == ST_RUN) cnt_q <= cnt_inc;
  end

  // DONE/ERR flags; a completion in the same cycle as a W1C leaves DONE set
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (start_req) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (stat_wr && wr_bits[STAT_DONE]) done_q <= 1'b0;
      if (stat_wr && wr_bits[STAT_ERR])  err_q  <= 1'b0;
      if (run_done)    done_q <= 1'b1;
      if (run_timeout) err_q  <= 1'b1;
    end
  end

  // CTRL fields: IRQ_EN always writable, INIT only latched while idle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      init_q   <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en_q <= wr_bits[CTRL_IRQ_EN];
      if (!busy) init_q <= wr_bits[CTRL_INIT];
    end
  end

  // Digest capture on completion only
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)      dig_q <= '0;
    else if (run_done) dig_q <= core_digest;
  end

  assign core_init = init_q;
  assign irq       = done_q && irq_en_q;

endmodule

// File: tb/tb_sha1_wb_sequencer.sv
// Self-checking bench for sha1_wb_sequencer: register-map vectors, hand-written
// job sequences for the corner cases and randomized traffic against a register model.
module tb_sha1_wb_sequencer;
  import sha1_pkg::*;

  logic                clk, rst;
  logic                core_start, core_init, core_done, irq;
  logic [BLOCK_W-1:0]  core_block;
  logic [DIGEST_W-1:0] core_digest;

  sha1_wb_sequencer_if wbs ();

  sha1_wb_sequencer dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (wbs),
    .core_start  (core_start),
    .core_init   (core_init),
    .core_block  (core_block),
    .core_done   (core_done),
    .core_digest (core_digest),
    .irq         (irq)
  );

  localparam logic [31:0] BASE = 32'h3000_0000;

  int n_checks = 0, n_fail = 0;
  int cyc_cnt = 0, start_cnt = 0, start_cyc = 0;
  bit auto_core = 0;
  int core_delay = 0;
  logic [DIGEST_W-1:0] model_dig;

  // Register model
  logic [31:0] m_msg [MSG_WORDS];
  logic [31:0] m_dig [DIG_WORDS];
  logic m_done, m_err, m_busy, m_init, m_irq_en;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Cycle counter and core_start observer, sampled just after each rising edge
  initial forever begin
    @(posedge clk);
    #2;
    cyc_cnt++;
    if (core_start) begin
      start_cnt++;
      start_cyc = cyc_cnt;
    end
  end

  // Behavioural SHA-1 core stand-in: done pulse core_delay cycles after start
  initial forever begin
    @(negedge clk);
    if (auto_core && core_start && core_delay > 0) begin
      repeat (core_delay) @(negedge clk);
      core_done   = 1'b1;
      core_digest = model_dig;
      @(negedge clk);
      core_done   = 1'b0;
      core_digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] off);
    if (off == 8'h00) return {29'b0, m_irq_en, m_init, 1'b0};
    if (off == 8'h04) return {29'b0, m_err, m_done, m_busy};
    if (off >= 8'h40 && off <= 8'h7C && off[1:0] == 2'b00) return m_msg[int'((off - 8'h40) >> 2)];
    if (off >= 8'h80 && off <= 8'h90 && off[1:0] == 2'b00) return m_dig[int'((off - 8'h80) >> 2)];
    return 32'h0;
  endfunction

  function automatic logic [BLOCK_W-1:0] exp_block();
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < MSG_WORDS; i++) b[BLOCK_W-1-32*i -: 32] = m_msg[i];
    return b;
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
    if (off == 8'h00) begin
      m_irq_en = d[2];
      if (!m_busy) begin
        m_init = d[1];
        if (d[0]) begin
          m_done = 0; m_err = 0; m_busy = 1;
        end
      end
    end else if (off == 8'h04) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end else if (off >= 8'h40 && off <= 8'h7C && off[1:0] == 2'b00 && !m_busy) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) m_msg[int'((off - 8'h40) >> 2)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MSG_WORDS; i++) m_msg[i] = '0;
    for (int i = 0; i < DIG_WORDS; i++) m_dig[i] = '0;
    m_done = 0; m_err = 0; m_busy = 0; m_init = 0; m_irq_en = 0;
  endtask

  // One Wishbone access starting at a falling edge; checks ack latency and width
  task automatic bus_access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                            input logic [3:0] sel, output logic [31:0] rd);
    int n;
    n = 0;
    wbs.wbs_adr_i = adr; wbs.wbs_we_i = we; wbs.wbs_dat_i = wd; wbs.wbs_sel_i = sel;
    wbs.wbs_stb_i = 1'b1; wbs.wbs_cyc_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!wbs.wbs_ack_o && n < 8);
    rd = wbs.wbs_dat_o;
    wbs.wbs_stb_i = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_we_i = 1'b0;
    check("ack_latency", 512'(n), 512'(1));
    @(negedge clk);
    check("ack_width", 512'(wbs.wbs_ack_o), 512'(0));
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] unused_rd;
    bus_access(BASE | {24'h0, off}, 1'b1, d, sel, unused_rd);
    model_write(off, d, sel);
  endtask

  task automatic rd_raw(input logic [7:0] off, output logic [31:0] r);
    bus_access(BASE | {24'h0, off}, 1'b0, 32'h0, 4'h0, r);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off);
    logic [31:0] r;
    rd_raw(off, r);
    check(name, 512'(r), 512'(exp_read(off)));
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int polls;
    s = 32'h1;
    polls = 0;
    while (s[0] && polls < 400) begin
      rd_raw(8'h04, s);
      polls++;
    end
    check("wait_idle", 512'(s[0]), 512'(0));
  endtask

  task automatic job_done(input logic [DIGEST_W-1:0] d);
    m_busy = 0;
    m_done = 1;
    for (int i = 0; i < DIG_WORDS; i++) m_dig[i] = d[DIGEST_W-1-32*i -: 32];
  endtask

  task automatic check_results(input string tag);
    rd_chk({tag, "_stat"}, 8'h04);
    for (int i = 0; i < DIG_WORDS; i++) rd_chk($sformatf("%s_dig%0d", tag, i), 8'(8'h80 + 4*i));
    check({tag, "_irq"}, 512'(irq), 512'(m_done & m_irq_en));
  endtask

  task automatic start_job(input logic init, input logic irq_en);
    int prev;
    prev = start_cnt;
    wr(8'h00, {29'b0, irq_en, init, 1'b1}, 4'hF);
    check("start_pulse", 512'(start_cnt), 512'(prev + 1));
  endtask

  initial begin
    vec_t vecs[$];
    logic [DIGEST_W-1:0] d;
    logic [31:0] r;
    int prev, acks;
    logic [5:0] ack_pat;

    rst = 1'b1;
    wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0; wbs.wbs_we_i = 0;
    wbs.wbs_sel_i = 0; wbs.wbs_dat_i = 0; wbs.wbs_adr_i = 0;
    core_done = 0;
    core_digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_core_start", 512'(core_start), 512'(0));
    check("rst_core_init", 512'(core_init), 512'(0));
    check("rst_core_block", core_block, 512'(0));
    check("rst_irq", 512'(irq), 512'(0));

    // Register map vectors, including byte-lane writes and unmapped offsets
    vecs.push_back('{we: 0, adr: 32'h3000_0000, dat: 0, sel: 0, exp: 32'h0});
    vecs.push_back('{we: 0, adr: 32'h3000_0004, dat: 0, sel: 0, exp: 32'h0});
    vecs.push_back('{we: 0, adr: 32'h3000_0040, dat: 0, sel: 0, exp: 32'h0});
    vecs.push_back('{we: 0, adr: 32'h3000_0090, dat: 0, sel: 0, exp: 32'h0});
    vecs.push_back('{we: 1, adr: 32'h3000_0040, dat: 32'h1122_3344, sel: 4'hF, exp: 0});
    vecs.push_back('{we: 1, adr: 32'h3000_0040, dat: 32'h0000_AB00, sel: 4'b0010, exp: 0});
    vecs.push_back('{we: 0, adr: 32'h3000_0040, dat: 0, sel: 0, exp: 32'h1122_AB44});
    vecs.push_back('{we: 0, adr: 32'h3000_00F0, dat: 0, sel: 0, exp: 32'h0});
    vecs.push_back('{we: 0, adr: 32'h3000_0008, dat: 0, sel: 0, exp: 32'h0});
    vecs.push_back('{we: 0, adr: 32'h3000_0094, dat: 0, sel: 0, exp: 32'h0});
    vecs.push_back('{we: 0, adr: 32'h3000_0041, dat: 0, sel: 0, exp: 32'h0});
    vecs.push_back('{we: 1, adr: 32'h3000_007C, dat: 32'hA5A5_A5A5, sel: 4'b1001, exp: 0});
    vecs.push_back('{we: 0, adr: 32'h3000_007C, dat: 0, sel: 0, exp: 32'hA500_00A5});
    vecs.push_back('{we: 1, adr: 32'h3000_0090, dat: 32'hFFFF_FFFF, sel: 4'hF, exp: 0});
    vecs.push_back('{we: 0, adr: 32'h3000_0090, dat: 0, sel: 0, exp: 32'h0});
    foreach (vecs[i]) begin
      bus_access(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, r);
      if (vecs[i].we) model_write(vecs[i].adr[7:0], vecs[i].dat, vecs[i].sel);
      else            check($sformatf("vec%0d", i), 512'(r), 512'(vecs[i].exp));
    end

    // Back-to-back strobe: ack on alternate cycles
    wbs.wbs_adr_i = BASE | 32'h40; wbs.wbs_we_i = 0; wbs.wbs_stb_i = 1; wbs.wbs_cyc_i = 1;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      ack_pat[i] = wbs.wbs_ack_o;
    end
    wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0;
    @(negedge clk);
    check("b2b_ack_pattern", 512'(ack_pat), 512'(6'b101010));

    // Out-of-window address is never acked
    acks = 0;
    wbs.wbs_adr_i = 32'h3000_0100; wbs.wbs_stb_i = 1; wbs.wbs_cyc_i = 1;
    repeat (5) begin
      @(negedge clk);
      if (wbs.wbs_ack_o) acks++;
    end
    wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0;
    @(negedge clk);
    check("oor_no_ack", 512'(acks), 512'(0));

    // "abc" job
    wr(8'h40, 32'h6162_6380, 4'hF);
    for (int i = 1; i < 15; i++) wr(8'(8'h40 + 4*i), 32'h0, 4'hF);
    wr(8'h7C, 32'h0000_0018, 4'hF);
    auto_core  = 1;
    core_delay = 80;
    model_dig  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    start_job(1'b1, 1'b1);
    check("abc_block", core_block, {32'h6162_6380, 448'h0, 32'h18});
    check("abc_init", 512'(core_init), 512'(1));
    wait_idle();
    job_done(model_dig);
    check_results("abc");
    check("abc_stat_is_2", 512'(exp_read(8'h04)), 512'(32'h2));

    // W1C of DONE in the same cycle the core completes: set wins
    auto_core = 0;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    start_job(1'b0, 1'b1);
    check("chain_init", 512'(core_init), 512'(0));
    repeat (3) @(negedge clk);
    core_done = 1; core_digest = d;
    wbs.wbs_adr_i = BASE | 32'h04; wbs.wbs_we_i = 1; wbs.wbs_dat_i = 32'h2; wbs.wbs_sel_i = 4'hF;
    wbs.wbs_stb_i = 1; wbs.wbs_cyc_i = 1;
    @(negedge clk);
    core_done = 0; core_digest = ~d;
    check("w1c_race_ack", 512'(wbs.wbs_ack_o), 512'(1));
    wbs.wbs_stb_i = 0; wbs.wbs_cyc_i = 0; wbs.wbs_we_i = 0;
    @(negedge clk);
    job_done(d);
    check_results("w1c_race");
    wr(8'h04, 32'h2, 4'hF);
    rd_chk("w1c_clear_stat", 8'h04);
    check("w1c_clear_irq", 512'(irq), 512'(0));

    // Writes while busy: acked, MSG and START ignored, IRQ_EN honoured
    auto_core  = 1;
    core_delay = 100;
    model_dig  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    prev = start_cnt;
    wr(8'h00, 32'h5, 4'hF);
    wr(8'h4C, 32'hDEAD_BEEF, 4'hF);
    wr(8'h00, 32'h1, 4'hF);
    wait_idle();
    job_done(model_dig);
    check("busy_one_start", 512'(start_cnt), 512'(prev + 1));
    rd_chk("busy_msg3", 8'h4C);
    rd_chk("busy_ctrl", 8'h00);
    check_results("busy");

    // Timeout: read STAT one cycle before and right after the limit
    core_delay = 0;
    for (int k = 0; k < 2; k++) begin
      start_job(1'b1, 1'b1);
      while (cyc_cnt < start_cyc + 1023 + k) @(negedge clk);
      rd_raw(8'h04, r);
      check($sformatf("tmo_edge%0d", k), 512'(r), 512'(k == 0 ? 32'h1 : 32'h4));
      wait_idle();
      m_busy = 0;
      m_err  = 1;
      check_results($sformatf("tmo%0d", k));
    end

    // core_done while idle is ignored
    core_done = 1; core_digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    core_done = 0;
    check_results("idle_done");

    // Randomized traffic against the register model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: wr(8'(8'h40 + 4*$urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        1: rd_chk("rand_rd", 8'($urandom_range(0, 255)));
        2: begin
          core_delay = $urandom_range(1, 60);
          model_dig  = {$urandom, $urandom, $urandom, $urandom, $urandom};
          start_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          check("rand_block", core_block, exp_block());
          check("rand_init", 512'(core_init), 512'(m_init));
          wait_idle();
          job_done(model_dig);
          check_results("rand_job");
        end
        default: begin
          wr(8'h00, {29'b0, 2'($urandom_range(0, 3)), 1'b0}, 4'hF);
          rd_chk("rand_ctrl", 8'h00);
          check("rand_irq", 512'(irq), 512'(m_done & m_irq_en));
        end
      endcase
    end

    // Asynchronous reset in the middle of a job
    core_delay = 0;
    wr(8'h40, 32'hCAFE_F00D, 4'hF);
    start_job(1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("pre_rst_init", 512'(core_init), 512'(1));
    check("pre_rst_block", core_block, exp_block());
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", 512'(wbs.wbs_ack_o), 512'(0));
    check("mid_rst_dat", 512'(wbs.wbs_dat_o), 512'(0));
    check("mid_rst_start", 512'(core_start), 512'(0));
    check("mid_rst_init", 512'(core_init), 512'(0));
    check("mid_rst_block", core_block, 512'(0));
    check("mid_rst_irq", 512'(irq), 512'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rd_chk("post_rst_stat", 8'h04);
    rd_chk("post_rst_ctrl", 8'h00);
    rd_chk("post_rst_msg0", 8'h40);
    rd_chk("post_rst_dig0", 8'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
